// File: rtl/elevator.sv
// -----------------------------------------------------------------------------
// elevator
// Single-car controller for a FLOORS-floor shaft using a collective (SCAN)
// policy. Call buttons are latched into a pending-call register. The car moves
// one floor every TRAVEL_CYCLES clocks, keeps its direction while calls remain
// ahead, and opens the door for DOOR_CYCLES clocks at each requested floor.
//
// Optional feature: define ELEVATOR_HOME_RETURN_EN to make an idle car with no
// pending calls return to floor 0 after HOME_IDLE_CYCLES idle cycles.
//
// Ports:
//   clk          in   1       rising-edge clock
//   rst          in   1       asynchronous active-high reset
//   floor_req    in   FLOORS  call buttons (a one-cycle pulse is enough)
//   floor_pos    out  POS_W   current car floor
//   door_open    out  1       door open
//   moving_up    out  1       car travelling upward
//   moving_down  out  1       car travelling downward
// -----------------------------------------------------------------------------
module elevator #(
    parameter int FLOORS           = 8,
    parameter int POS_W            = 3,
    parameter int TRAVEL_CYCLES    = 4,
    parameter int DOOR_CYCLES      = 4,
    parameter int HOME_IDLE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLOORS-1:0] floor_req,
    output logic [POS_W-1:0]  floor_pos,
    output logic              door_open,
    output logic              moving_up,
    output logic              moving_down
);

    localparam int TMR_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MOVE_UP   = 2'd1,
        ST_MOVE_DOWN = 2'd2,
        ST_DOOR      = 2'd3
    } state_t;

    // Elaboration-time parameter sanity checks
    if ((1 << POS_W) < FLOORS) begin : g_pos_w_chk
        $error("POS_W too small for FLOORS");
    end
    if ((TRAVEL_CYCLES < 1) || (DOOR_CYCLES < 1) || (HOME_IDLE_CYCLES < 1)) begin : g_cyc_chk
        $error("cycle parameters must be >= 1");
    end

    // Any pending call strictly above pos
    function automatic logic calls_above(input logic [FLOORS-1:0] req, input logic [POS_W-1:0] pos);
        logic hit;
        hit = 1'b0;
        for (int f = 0; f < FLOORS; f++) begin
            if ((f > int'(pos)) && req[f]) begin
                hit = 1'b1;
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

    // Any pending call strictly below pos
    function automatic logic calls_below(input logic [FLOORS-1:0] req, input logic [POS_W-1:0] pos);
        logic hit;
        hit = 1'b0;
        for (int f = 0; f < FLOORS; f++) begin
            if ((f < int'(pos)) && req[f]) begin
                hit = 1'b1;
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

    // One-hot mask selecting floor pos
    function automatic logic [FLOORS-1:0] floor_mask(input logic [POS_W-1:0] pos);
        logic [FLOORS-1:0] m;
        m      = {FLOORS{1'b0}};
        m[pos] = 1'b1;
        return m;
    endfunction

    state_t              r_state;
    logic [POS_W-1:0]    r_floor_pos;
    logic [FLOORS-1:0]   r_req_q;
    logic                r_dir;      // 1 = up
    logic [TMR_W-1:0]    r_timer;

    state_t              w_state_nxt;
    logic [POS_W-1:0]    w_pos_nxt;
    logic [FLOORS-1:0]   w_req_nxt;
    logic                w_dir_nxt;
    logic [TMR_W-1:0]    w_timer_nxt;

    logic [FLOORS-1:0]   w_req_in;
    logic [FLOORS-1:0]   w_req_eff;
    logic [POS_W-1:0]    w_next_floor;
    logic                w_door_reload;
    logic                w_home_req;

`ifdef ELEVATOR_HOME_RETURN_EN
    localparam int HC_W = $clog2(HOME_IDLE_CYCLES + 1);

    logic [HC_W-1:0]     r_home_cnt;
    logic                w_home_cond;

    assign w_home_cond = (r_state == ST_IDLE) && (r_req_q == {FLOORS{1'b0}})
                         && (r_floor_pos != {POS_W{1'b0}});
    assign w_home_req  = w_home_cond && (r_home_cnt == HC_W'(HOME_IDLE_CYCLES - 1));

    // Idle-at-floor counter; clears whenever the car is busy, has calls, or is home
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_home_cnt <= {HC_W{1'b0}};
        end else if (w_home_cond && !w_home_req) begin
            r_home_cnt <= r_home_cnt + HC_W'(1);
        end else begin
            r_home_cnt <= {HC_W{1'b0}};
        end
    end
`else
    assign w_home_req = 1'b0;
`endif

    // Request intake: a press for the floor with the door open only restarts
    // the door timer and is never latched.
    always_comb begin
        w_req_in      = floor_req;
        w_door_reload = 1'b0;
        if (r_state == ST_DOOR) begin
            w_door_reload = floor_req[r_floor_pos];
            w_req_in      = floor_req & ~floor_mask(r_floor_pos);
        end else begin
            w_req_in[0] = floor_req[0] | w_home_req;
        end
        w_req_eff    = r_req_q | w_req_in;
        w_next_floor = (r_state == ST_MOVE_UP) ? (r_floor_pos + POS_W'(1))
                                               : (r_floor_pos - POS_W'(1));
    end

    // Next-state, position, pending-call and timer logic
    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = r_floor_pos;
        w_req_nxt   = w_req_eff;
        w_dir_nxt   = r_dir;
        w_timer_nxt = r_timer;
        case (r_state)
            ST_IDLE: begin
                if (r_req_q[r_floor_pos]) begin
                    w_state_nxt = ST_DOOR;
                    w_req_nxt   = w_req_eff & ~floor_mask(r_floor_pos);
                    w_timer_nxt = TMR_W'(DOOR_CYCLES - 1);
                end else if (calls_above(r_req_q, r_floor_pos)
                             && (!calls_below(r_req_q, r_floor_pos) || r_dir)) begin
                    w_state_nxt = ST_MOVE_UP;
                    w_dir_nxt   = 1'b1;
                    w_timer_nxt = TMR_W'(TRAVEL_CYCLES - 1);
                end else if (calls_below(r_req_q, r_floor_pos)) begin
                    w_state_nxt = ST_MOVE_DOWN;
                    w_dir_nxt   = 1'b0;
                    w_timer_nxt = TMR_W'(TRAVEL_CYCLES - 1);
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_MOVE_UP, ST_MOVE_DOWN: begin
                if (r_timer != {TMR_W{1'b0}}) begin
                    w_timer_nxt = r_timer - TMR_W'(1);
                end else begin
                    // Arrival: the new floor's call may have arrived this very cycle
                    w_pos_nxt = w_next_floor;
                    if (w_req_eff[w_next_floor]) begin
                        w_state_nxt = ST_DOOR;
                        w_req_nxt   = w_req_eff & ~floor_mask(w_next_floor);
                        w_timer_nxt = TMR_W'(DOOR_CYCLES - 1);
                    end else if ((r_state == ST_MOVE_UP) ? calls_above(w_req_eff, w_next_floor)
                                                         : calls_below(w_req_eff, w_next_floor)) begin
                        w_timer_nxt = TMR_W'(TRAVEL_CYCLES - 1);
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_timer_nxt = {TMR_W{1'b0}};
                    end
                end
            end
            ST_DOOR: begin
                if (w_door_reload) begin
                    w_timer_nxt = TMR_W'(DOOR_CYCLES - 1);
                end else if (r_timer == {TMR_W{1'b0}}) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer - TMR_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_timer_nxt = {TMR_W{1'b0}};
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_floor_pos <= {POS_W{1'b0}};
            r_req_q     <= {FLOORS{1'b0}};
            r_dir       <= 1'b1;
            r_timer     <= {TMR_W{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_floor_pos <= w_pos_nxt;
            r_req_q     <= w_req_nxt;
            r_dir       <= w_dir_nxt;
            r_timer     <= w_timer_nxt;
        end
    end

    assign floor_pos   = r_floor_pos;
    assign door_open   = (r_state == ST_DOOR);
    assign moving_up   = (r_state == ST_MOVE_UP);
    assign moving_down = (r_state == ST_MOVE_DOWN);

endmodule

// File: tb/tb_elevator.sv
// -----------------------------------------------------------------------------
// tb_elevator
// Directed testbench for elevator with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_elevator;

    logic       clk;
    logic       rst;
    logic [7:0] floor_req;
    logic [2:0] floor_pos;
    logic       door_open;
    logic       moving_up;
    logic       moving_down;

    int n_cmp;
    int n_err;

    elevator #(
        .FLOORS(8), .POS_W(3), .TRAVEL_CYCLES(4), .DOOR_CYCLES(4), .HOME_IDLE_CYCLES(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .floor_req  (floor_req),
        .floor_pos  (floor_pos),
        .door_open  (door_open),
        .moving_up  (moving_up),
        .moving_down(moving_down)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for exactly one sampling edge (edge E)
    task automatic pulse(input logic [7:0] v);
        floor_req = v;
        tick();
        floor_req = 8'h00;
    endtask

    task automatic check_outs(input string tag, input int pos, input bit up, input bit dn, input bit door);
        check({tag, " pos"}, 32'(floor_pos), 32'(pos));
        check({tag, " up"}, 32'(moving_up), 32'(up));
        check({tag, " down"}, 32'(moving_down), 32'(dn));
        check({tag, " door"}, 32'(door_open), 32'(door));
    endtask

    // Called right after the request edge E (or after the previous leg's IDLE
    // cycle). Edge n: moving for n=1..4d, door for 4d+1..4d+4, idle at 4d+5.
    task automatic trip(input string tag, input int start, input int target);
        int d;
        int pos_e;
        bit up_e;
        bit dn_e;
        bit door_e;
        d = (target > start) ? (target - start) : (start - target);
        for (int n = 1; n <= 4 * d + 5; n++) begin
            tick();
            if (n <= 4 * d) begin
                pos_e = (target > start) ? (start + (n - 1) / 4) : (start - (n - 1) / 4);
            end else begin
                pos_e = target;
            end
            up_e   = (n <= 4 * d) && (target > start);
            dn_e   = (n <= 4 * d) && (target < start);
            door_e = (n > 4 * d) && (n <= 4 * d + 4);
            check_outs($sformatf("%s n%0d", tag, n), pos_e, up_e, dn_e, door_e);
        end
    endtask

    initial begin
        bit found;
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        floor_req = 8'h00;
        tick();
        tick();
        check_outs("reset", 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        check_outs("post reset", 0, 1'b0, 1'b0, 1'b0);

        // Call at the current floor: door only
        pulse(8'h01);
        check_outs("t1 E", 0, 1'b0, 1'b0, 1'b0);
        trip("t1", 0, 0);

        // 0 -> 3
        pulse(8'h08);
        trip("t2", 0, 3);

        // 3 -> 1
        pulse(8'h02);
        trip("t3", 3, 1);

        // From 1, calls at 2 and 5: stop at 2 then continue to 5
        pulse(8'h24);
        trip("t4a", 1, 2);
        trip("t4b", 2, 5);
        check("t4 req_q", 32'(dut.r_req_q), 32'h0);
        tick();
        check_outs("t4 idle", 5, 1'b0, 1'b0, 1'b0);

        // Door reload: re-press current floor while open
        pulse(8'h20);
        tick();
        check_outs("t5 n1", 5, 1'b0, 1'b0, 1'b1);
        tick();
        floor_req = 8'h20;
        tick();
        floor_req = 8'h00;
        tick();
        tick();
        tick();
        check_outs("t5 n6", 5, 1'b0, 1'b0, 1'b1);
        tick();
        check_outs("t5 n7", 5, 1'b0, 1'b0, 1'b0);
        check("t5 req_q", 32'(dut.r_req_q), 32'h0);

        // Reset while moving down from 5 to 0
        pulse(8'h01);
        for (int i = 0; i < 6; i++) tick();
        check_outs("t6 moving", 4, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        check_outs("t6 rst", 0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check_outs("t6 after", 0, 1'b0, 1'b0, 1'b0);
        check("t6 req_q", 32'(dut.r_req_q), 32'h0);

        // Idle at floor 3 with no calls
        pulse(8'h08);
        trip("t7", 0, 3);
`ifdef ELEVATOR_HOME_RETURN_EN
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!found && door_open && (floor_pos == 3'd0)) found = 1'b1;
        end
        check("t7 home door", 32'(found), 32'h1);
        check("t7 home pos", 32'(floor_pos), 32'h0);
`else
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (floor_pos != 3'd3 || moving_up || moving_down || door_open) found = 1'b1;
        end
        check("t7 stay changed", 32'(found), 32'h0);
        check("t7 stay pos", 32'(floor_pos), 32'h3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
